// File: rtl/iodelay_ctrl_pkg.sv
// Shared types and helpers for the IODELAY tap sequencer.
package iodelay_ctrl_pkg;

    localparam int TAP_W     = 5;
    localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;
    localparam int CNT_W     = 10;
    localparam int MAX_LANES = 32;
    localparam int VEC_W     = TAP_W * MAX_LANES;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_LOAD     = 3'd2,
        S_SETTLE   = 3'd3,
        S_DWELL    = 3'd4,
        S_CHECK    = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    // Extract the 5-bit CNTVALUEOUT slice of lane i from a zero-extended bus.
    function automatic logic [TAP_W-1:0] lane_tap(input logic [VEC_W-1:0] vec,
                                                  input int unsigned      i);
        logic [VEC_W-1:0] sh;
        sh = vec >> (TAP_W * i);
        return sh[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/iodelay_tap_ctrl.sv
// IODELAY tap sequencer: loads one lane at a time over a shared CNTVALUEIN bus,
// confirms the load through CNTVALUEOUT, and optionally sweeps taps 0..31.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request
// WAIT_RDY | request accepted, waiting for IDELAYCTRL RDY
// LOAD     | one-cycle LD pulse on the target lane
// SETTLE   | wait SETTLE_CYC cycles for CNTVALUEOUT to reflect the load
// CHECK    | compare readback against the requested tap
// DWELL    | sweep only: hold tap for DWELL_CYC, strobe on the last cycle
// RESP     | one-cycle completion pulse
module iodelay_tap_ctrl
    import iodelay_ctrl_pkg::*;
#(
    parameter int NLANES     = 8,
    parameter int SETTLE_CYC = 4,
    parameter int DWELL_CYC  = 64,
    parameter int LANE_W     = $clog2(NLANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dly_rdy,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [LANE_W-1:0]       req_lane,
    input  logic [TAP_W-1:0]        req_tap,
    input  logic                    req_sweep,
    output logic                    rsp_valid,
    output logic [LANE_W-1:0]       rsp_lane,
    output logic [TAP_W-1:0]        rsp_tap,
    output logic                    rsp_err,
    output logic [TAP_W-1:0]        cntvaluein,
    output logic [NLANES-1:0]       ld,
    input  logic [NLANES*TAP_W-1:0] cntvalueout,
    output logic                    sample_stb,
    output logic [TAP_W-1:0]        sample_tap,
    output logic                    busy
);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST  = CNT_W'(DWELL_CYC - 1);
    localparam logic [LANE_W:0]   NLANES_EXT  = (LANE_W + 1)'(NLANES);

    // Parameter range guards, evaluated at elaboration.
    if (SETTLE_CYC < 2 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("iodelay_tap_ctrl: SETTLE_CYC out of range 2..15");
    end
    if (DWELL_CYC < 1 || DWELL_CYC > 1023) begin : g_bad_dwell
        $error("iodelay_tap_ctrl: DWELL_CYC out of range 1..1023");
    end
    if (NLANES < 2 || NLANES > MAX_LANES) begin : g_bad_nlanes
        $error("iodelay_tap_ctrl: NLANES out of range 2..32");
    end

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic                sweep_q, sweep_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAP_W-1:0]    cval_q, cval_d;
    logic                ready_en_q, ready_en_d;

    logic                handshake;
    logic                lane_bad;
    logic [TAP_W-1:0]    readback;
    logic [TAP_W-1:0]    req_tap_eff;

    assign handshake   = req_valid & req_ready;
    assign lane_bad    = {1'b0, req_lane} >= NLANES_EXT;
    assign readback    = lane_tap(VEC_W'(cntvalueout), 32'(lane_q));
    assign req_tap_eff = req_sweep ? '0 : req_tap;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        tap_d      = tap_q;
        sweep_d    = sweep_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        cval_d     = cval_q;
        ready_en_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    lane_d  = req_lane;
                    tap_d   = req_tap_eff;
                    sweep_d = req_sweep;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (lane_bad) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else if (dly_rdy) begin
                        state_d = S_LOAD;
                        cval_d  = req_tap_eff;
                    end else begin
                        state_d = S_WAIT_RDY;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (dly_rdy) begin
                    state_d = S_LOAD;
                    cval_d  = tap_q;
                end
            end
            S_LOAD: begin
                cnt_d = '0;
                if (!dly_rdy) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!dly_rdy) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (!dly_rdy || readback != tap_q) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (sweep_q) begin
                    state_d = S_DWELL;
                end else begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                end
            end
            S_DWELL: begin
                if (!dly_rdy) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (cnt_q == DWELL_LAST) begin
                    // Sweep stops at the top tap rather than wrapping.
                    if (tap_q == TAP_MAX) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LOAD;
                        tap_d   = tap_q + 1'b1;
                        cval_d  = tap_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            tap_q      <= '0;
            sweep_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            cval_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            tap_q      <= tap_d;
            sweep_q    <= sweep_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            cval_q     <= cval_d;
            ready_en_q <= ready_en_d;
        end
    end

    // Output decode; LD is gated directly by RDY so it can never fire while RDY is low.
    always_comb begin
        req_ready  = ready_en_q & (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        cntvaluein = cval_q;
        ld         = '0;
        if (state_q == S_LOAD && dly_rdy) begin
            ld = NLANES'(1) << lane_q;
        end
        sample_stb = (state_q == S_DWELL) && dly_rdy && (cnt_q == DWELL_LAST);
        sample_tap = sample_stb ? tap_q : '0;
        rsp_valid  = (state_q == S_RESP);
        rsp_lane   = rsp_valid ? lane_q : '0;
        rsp_tap    = rsp_valid ? tap_q : '0;
        rsp_err    = rsp_valid & err_q;
    end

endmodule

// File: tb/tb_iodelay_tap_ctrl.sv
// Directed bench for iodelay_tap_ctrl with a behavioural IODELAY lane model.
module tb_iodelay_tap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dly_rdy;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_lane;
    logic [4:0]  req_tap;
    logic        req_sweep;
    logic        rsp_valid;
    logic [2:0]  rsp_lane;
    logic [4:0]  rsp_tap;
    logic        rsp_err;
    logic [4:0]  cntvaluein;
    logic [7:0]  ld;
    logic [39:0] cntvalueout;
    logic        sample_stb;
    logic [4:0]  sample_tap;
    logic        busy;

    // Second instance with NLANES=6 so an out-of-range lane is encodable.
    logic        s_req_valid;
    logic        s_req_ready;
    logic [2:0]  s_req_lane;
    logic        s_rsp_valid;
    logic [2:0]  s_rsp_lane;
    logic [4:0]  s_rsp_tap;
    logic        s_rsp_err;
    logic [4:0]  s_cntvaluein;
    logic [5:0]  s_ld;
    logic        s_sample_stb;
    logic [4:0]  s_sample_tap;
    logic        s_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ld_cnt = 0;
    int s_ld_cnt = 0;
    int rsp_cnt = 0;
    int rsp_cyc = 0;
    int stb_tap[$];
    int stb_cyc[$];
    logic       stuck = 1'b0;
    logic [4:0] lane_val [8];

    always #5 clk = ~clk;

    iodelay_tap_ctrl #(.NLANES(8), .SETTLE_CYC(4), .DWELL_CYC(4)) u_dut (
        .clk(clk), .rst(rst), .dly_rdy(dly_rdy),
        .req_valid(req_valid), .req_ready(req_ready), .req_lane(req_lane),
        .req_tap(req_tap), .req_sweep(req_sweep),
        .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_tap(rsp_tap), .rsp_err(rsp_err),
        .cntvaluein(cntvaluein), .ld(ld), .cntvalueout(cntvalueout),
        .sample_stb(sample_stb), .sample_tap(sample_tap), .busy(busy)
    );

    iodelay_tap_ctrl #(.NLANES(6), .SETTLE_CYC(4), .DWELL_CYC(4)) u_small (
        .clk(clk), .rst(rst), .dly_rdy(1'b1),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_lane(s_req_lane),
        .req_tap(5'd3), .req_sweep(1'b0),
        .rsp_valid(s_rsp_valid), .rsp_lane(s_rsp_lane), .rsp_tap(s_rsp_tap), .rsp_err(s_rsp_err),
        .cntvaluein(s_cntvaluein), .ld(s_ld), .cntvalueout(30'd0),
        .sample_stb(s_sample_stb), .sample_tap(s_sample_tap), .busy(s_busy)
    );

    // Lane model: CNTVALUEOUT takes CNTVALUEIN one cycle after LD.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) lane_val[i] <= 5'd0;
        end else begin
            for (int i = 0; i < 8; i++) if (ld[i]) lane_val[i] <= cntvaluein;
        end
    end

    always_comb begin
        cntvalueout = '0;
        for (int i = 0; i < 8; i++) cntvalueout[i*5 +: 5] = stuck ? 5'd0 : lane_val[i];
    end

    always @(posedge clk) cyc++;

    // Passive monitor: LD legality, pulse counting, strobe log.
    always @(negedge clk) begin
        if (ld != 0) begin
            ld_cnt++;
            total++;
            assert ($onehot(ld) && dly_rdy) else begin
                bad++;
                $error("FAIL ld_legal observed ld=%b rdy=%b expected one-hot with rdy=1", ld, dly_rdy);
            end
        end
        if (s_ld != 0) s_ld_cnt++;
        if (sample_stb) begin
            stb_tap.push_back(int'(sample_tap));
            stb_cyc.push_back(cyc);
        end
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < budget);
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        int r0;
        int found;
        rst = 1'b1; dly_rdy = 1'b1; req_valid = 1'b0; req_lane = '0; req_tap = '0;
        req_sweep = 1'b0; s_req_valid = 1'b0; s_req_lane = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ld", {24'd0, ld}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_cntvaluein", {27'd0, cntvaluein}, 0);
        chk("rst_sample_stb", {31'd0, sample_stb}, 0);
        rst = 1'b0;
        chk("rdy_low_first_cycle", {31'd0, req_ready}, 0);
        @(negedge clk);
        chk("rdy_after_rst", {31'd0, req_ready}, 1);

        // Single load lane 3 tap 17
        req_valid = 1'b1; req_lane = 3'd3; req_tap = 5'd17;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t1_ld", {24'd0, ld}, 32'h08);
        chk("t1_cval", {27'd0, cntvaluein}, 17);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_ready_low", {31'd0, req_ready}, 0);
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            chk("t1_ld_once", {24'd0, ld}, 0);
            chk("t1_rsp_timing", {31'd0, rsp_valid}, (c == 7) ? 1 : 0);
            if (c == 7) begin
                chk("t1_rsp_err", {31'd0, rsp_err}, 0);
                chk("t1_rsp_tap", {27'd0, rsp_tap}, 17);
                chk("t1_rsp_lane", {29'd0, rsp_lane}, 3);
            end
        end
        chk("t1_ready_back", {31'd0, req_ready}, 1);
        chk("t1_cval_hold", {27'd0, cntvaluein}, 17);

        // RDY low at request, raised 20 cycles later
        dly_rdy = 1'b0;
        req_valid = 1'b1; req_lane = 3'd5; req_tap = 5'd6;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk("t2_busy_wait", {31'd0, busy}, 1);
            chk("t2_no_ld", {24'd0, ld}, 0);
            @(negedge clk);
        end
        dly_rdy = 1'b1;
        @(negedge clk);
        chk("t2_ld", {24'd0, ld}, 32'h20);
        chk("t2_cval", {27'd0, cntvaluein}, 6);
        wait_rsp(12);
        chk("t2_rsp_err", {31'd0, rsp_err}, 0);
        chk("t2_rsp_tap", {27'd0, rsp_tap}, 6);
        chk("t2_rsp_lane", {29'd0, rsp_lane}, 5);
        chk("t2_busy_at_rsp", {31'd0, busy}, 1);
        @(negedge clk);

        // Readback stuck at zero
        stuck = 1'b1;
        l0 = ld_cnt;
        req_valid = 1'b1; req_lane = 3'd2; req_tap = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(12);
        chk("t3_rsp_err", {31'd0, rsp_err}, 1);
        chk("t3_rsp_tap", {27'd0, rsp_tap}, 9);
        repeat (3) @(negedge clk);
        chk("t3_ld_count", ld_cnt - l0, 1);
        stuck = 1'b0;

        // Full sweep on lane 0
        stb_tap.delete(); stb_cyc.delete();
        l0 = ld_cnt;
        req_valid = 1'b1; req_lane = 3'd0; req_tap = 5'd22; req_sweep = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_sweep = 1'b0;
        wait_rsp(400);
        chk("t4_rsp_err", {31'd0, rsp_err}, 0);
        chk("t4_rsp_tap", {27'd0, rsp_tap}, 31);
        chk("t4_rsp_lane", {29'd0, rsp_lane}, 0);
        repeat (2) @(negedge clk);
        chk("t4_ld_count", ld_cnt - l0, 32);
        chk("t4_stb_count", stb_tap.size(), 32);
        if (stb_tap.size() == 32) begin
            for (int i = 0; i < 32; i++) chk("t4_stb_tap", stb_tap[i], i);
            for (int i = 1; i < 32; i++) chk("t4_stb_spacing", stb_cyc[i] - stb_cyc[i-1], 10);
            chk("t4_rsp_after_stb", rsp_cyc - stb_cyc[31], 1);
        end

        // RDY drop at tap 12 during sweep on lane 1
        req_valid = 1'b1; req_lane = 3'd1; req_sweep = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_sweep = 1'b0;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            if (ld[1] && cntvaluein == 5'd12) found = 1;
            else @(negedge clk);
        end
        chk("t5_reach_tap12", found, 1);
        @(negedge clk);
        dly_rdy = 1'b0;
        l0 = ld_cnt;
        wait_rsp(5);
        chk("t5_rsp_err", {31'd0, rsp_err}, 1);
        chk("t5_rsp_tap", {27'd0, rsp_tap}, 12);
        chk("t5_rsp_lane", {29'd0, rsp_lane}, 1);
        repeat (3) @(negedge clk);
        chk("t5_no_more_ld", ld_cnt - l0, 0);
        dly_rdy = 1'b1;
        @(negedge clk);

        // Reset in the middle of a sweep
        req_valid = 1'b1; req_lane = 3'd4; req_sweep = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_sweep = 1'b0;
        repeat (50) @(negedge clk);
        chk("t6_busy_pre", {31'd0, busy}, 1);
        r0 = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_ld", {24'd0, ld}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_ready", {31'd0, req_ready}, 0);
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("t6_stb", {31'd0, sample_stb}, 0);
        chk("t6_cval", {27'd0, cntvaluein}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_rsp", rsp_cnt - r0, 0);
        chk("t6_ready_back", {31'd0, req_ready}, 1);

        // Out-of-range lane on the 6-lane instance
        s_req_valid = 1'b1; s_req_lane = 3'd7;
        chk("t7_ready", {31'd0, s_req_ready}, 1);
        @(negedge clk);
        s_req_valid = 1'b0;
        chk("t7_rsp_valid", {31'd0, s_rsp_valid}, 1);
        chk("t7_rsp_err", {31'd0, s_rsp_err}, 1);
        chk("t7_rsp_lane", {29'd0, s_rsp_lane}, 7);
        chk("t7_ld", {26'd0, s_ld}, 0);
        repeat (3) @(negedge clk);
        chk("t7_ld_never", s_ld_cnt, 0);
        chk("t7_idle", {31'd0, s_busy}, 0);
        chk("t7_no_stb", {31'd0, s_sample_stb}, 0);
        chk("t7_cval", {27'd0, s_cntvaluein}, 0);
        chk("t7_stb_tap", {27'd0, s_sample_tap}, 0);
        chk("t7_rsp_tap_idle", {27'd0, s_rsp_tap}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
